// File: rtl/quad_ram_arb_pkg.sv
// Shared types and defaults for the quad-port RAM write arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package quad_ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4096;

  // Circular increment of a requester index in 0..n-1.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular first-set-bit finder: lowest set bit of mask at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: n/a.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IW:0]  pos;

  // Rotate so bit 0 is the start requester, take the lowest set bit, map back.
  always_comb begin
    rot   = N'({mask, mask} >> start);
    found = |rot;
    pos   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) pos = (IW+1)'(j);
    end
    pos = pos + {1'b0, start};
    if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
    idx = pos[IW-1:0];
  end

endmodule

// File: rtl/quad_port_ram_write_arbiter.sv
// Round-robin arbiter sharing RAM write ports A/B among NREQ requesters; optional
// post-reset zero-fill when QUAD_RAM_ARB_CLEAR_EN is defined.
// Latency: req_ready combinational; port registers drive the RAM the cycle after the handshake.
// Backpressure: requesters hold valid/addr/data until ready; none are ready while busy or in reset.
module quad_port_ram_write_arbiter
  import quad_ram_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic                         we_a,
  output logic                         we_b,
  output logic [ADDR_WIDTH-1:0]        addr_a,
  output logic [ADDR_WIDTH-1:0]        addr_b,
  output logic [DATA_WIDTH-1:0]        data_a,
  output logic [DATA_WIDTH-1:0]        data_b,
  output logic                         busy
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || DEPTH != (1 << ADDR_WIDTH)) begin : g_param_check
    $error("quad_port_ram_write_arbiter: unsupported NREQ/DEPTH/ADDR_WIDTH combination");
  end

  logic [IW-1:0]         ptr;
  logic [IW-1:0]         ptr_next;
  logic [ADDR_WIDTH-1:0] addr_of [NREQ];
  logic [DATA_WIDTH-1:0] data_of [NREQ];
  logic                  arb_en;
  logic                  found_a;
  logic                  found_b;
  logic                  grant_a;
  logic                  grant_b;
  logic [IW-1:0]         idx_a;
  logic [IW-1:0]         idx_b;
  logic [IW-1:0]         start_b;
  logic [NREQ-1:0]       mask_b;
  logic                  clear_active;
  logic [ADDR_WIDTH-1:0] clr_addr_a;
  logic [ADDR_WIDTH-1:0] clr_addr_b;

`ifdef QUAD_RAM_ARB_CLEAR_EN
  arb_state_t            state;
  arb_state_t            state_next;
  logic [ADDR_WIDTH-2:0] clr_cnt;
  logic [ADDR_WIDTH-2:0] clr_cnt_next;

  // Clear sequencer state and word-pair counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Walk word pairs 0..DEPTH/2-1, then hand the ports to arbitration.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign clear_active = (state == ST_CLEAR);
  assign clr_addr_a   = {clr_cnt, 1'b0};
  assign clr_addr_b   = {clr_cnt, 1'b1};
  assign busy         = clear_active || !rst_n;
  assign arb_en       = rst_n && !clear_active;
`else
  assign clear_active = 1'b0;
  assign clr_addr_a   = '0;
  assign clr_addr_b   = '0;
  assign busy         = 1'b0;
  assign arb_en       = rst_n;
`endif

  // Split the packed request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_of[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_of[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_priority_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .mask  (req_valid),
    .start (ptr),
    .found (found_a),
    .idx   (idx_a)
  );

  // Port B candidates: valid, and not colliding with A's address (this also drops A itself).
  always_comb begin
    start_b = IW'(wrap_inc(32'(idx_a), NREQ));
    mask_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask_b[i] = req_valid[i] && (addr_of[i] != addr_of[idx_a]);
    end
  end

  rr_priority_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .mask  (mask_b),
    .start (start_b),
    .found (found_b),
    .idx   (idx_b)
  );

  assign grant_a = arb_en && found_a;
  assign grant_b = grant_a && found_b;

  // Grants back to requesters and the pointer past the last winner.
  always_comb begin
    req_ready = '0;
    ptr_next  = ptr;
    if (grant_a) begin
      req_ready[idx_a] = 1'b1;
      ptr_next         = IW'(wrap_inc(32'(idx_a), NREQ));
    end
    if (grant_b) begin
      req_ready[idx_b] = 1'b1;
      ptr_next         = IW'(wrap_inc(32'(idx_b), NREQ));
    end
  end

  // Registered RAM write ports; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_a   <= 1'b0;
      we_b   <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      data_a <= '0;
      data_b <= '0;
      ptr    <= '0;
    end else if (clear_active) begin
      we_a   <= 1'b1;
      we_b   <= 1'b1;
      addr_a <= clr_addr_a;
      addr_b <= clr_addr_b;
      data_a <= '0;
      data_b <= '0;
    end else begin
      we_a <= grant_a;
      we_b <= grant_b;
      if (grant_a) begin
        addr_a <= addr_of[idx_a];
        data_a <= data_of[idx_a];
      end
      if (grant_b) begin
        addr_b <= addr_of[idx_b];
        data_b <= data_of[idx_b];
      end
      ptr <= ptr_next;
    end
  end

endmodule
